// File: rtl/logip_cmd_pkg.sv
// Shared opcode constants and enums for the SUMP command decoder.
// Short opcodes have bit 7 clear; long opcodes have bit 7 set and are
// followed by four little-endian argument bytes.
package logip_cmd_pkg;

    // Short (single byte) commands
    localparam logic [7:0] OP_RESET    = 8'h00;
    localparam logic [7:0] OP_ARM      = 8'h01;
    localparam logic [7:0] OP_ID       = 8'h02;
    localparam logic [7:0] OP_META     = 8'h04;
    localparam logic [7:0] OP_XON      = 8'h11;
    localparam logic [7:0] OP_XOFF     = 8'h13;

    // Long (opcode + 4 argument bytes) commands
    localparam logic [7:0] OP_STG_BASE = 8'hC0;
    localparam logic [7:0] OP_DIV      = 8'h80;
    localparam logic [7:0] OP_CNT      = 8'h81;
    localparam logic [7:0] OP_FLAGS    = 8'h82;

    // Stage sub-operation carried in opcode[1:0]
    typedef enum logic [1:0] {
        STG_MASK = 2'd0,
        STG_VAL  = 2'd1,
        STG_CFG  = 2'd2
    } stg_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        ARG  = 1'b1
    } dec_state_t;

    // Stage opcodes occupy 0xC0..0xCF; stage index is opcode[3:2].
    function automatic logic is_stage_op(input logic [7:0] op);
        return (op[7:4] == OP_STG_BASE[7:4]);
    endfunction

endpackage

// File: rtl/sump_cmd_decoder.sv
// SUMP host command decoder.
// Turns the received byte stream into short-command pulses and long-command
// config strobes with a shared 32-bit argument bus (cmd_o).
//
// Optional build macro: LOGIP_CMD_TIMEOUT_EN
//   When defined, an argument collection that stalls for TIMEOUT_CYC cycles
//   is abandoned and the decoder returns to IDLE without a strobe.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an opcode; bit7=0 decodes a short command at once
// ARG   | collecting 4 argument bytes for the latched long opcode
module sump_cmd_decoder
    import logip_cmd_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_in,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_stb_i,
    output logic [31:0]           cmd_o,
    output logic [NUM_STAGES-1:0] set_mask_o,
    output logic [NUM_STAGES-1:0] set_val_o,
    output logic [NUM_STAGES-1:0] set_cfg_o,
    output logic                  set_div_o,
    output logic                  set_cnt_o,
    output logic                  set_flags_o,
    output logic                  arm_o,
    output logic                  soft_rst_o,
    output logic                  id_o,
    output logic                  meta_o,
    output logic                  xon_o,
    output logic                  xoff_o,
    output logic                  busy_o
);

    localparam logic [2:0] NS_L = 3'(NUM_STAGES);

    dec_state_t            state_q, state_d;
    logic [7:0]            op_q, op_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [23:0]           shadow_q, shadow_d;
    logic [31:0]           cmd_q, cmd_d;

    logic [NUM_STAGES-1:0] set_mask_q, set_mask_d;
    logic [NUM_STAGES-1:0] set_val_q, set_val_d;
    logic [NUM_STAGES-1:0] set_cfg_q, set_cfg_d;
    logic                  set_div_q, set_div_d;
    logic                  set_cnt_q, set_cnt_d;
    logic                  set_flags_q, set_flags_d;
    logic                  arm_q, arm_d;
    logic                  soft_rst_q, soft_rst_d;
    logic                  id_q, id_d;
    logic                  meta_q, meta_d;
    logic                  xon_q, xon_d;
    logic                  xoff_q, xoff_d;

    logic [1:0]            stg_idx;
    logic [1:0]            stg_sub;
    logic                  stg_ok;
    logic [3:0]            stg_onehot;
    logic [NUM_STAGES-1:0] stg_sel;

`ifdef LOGIP_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

    // Stage address decode of the latched long opcode
    always_comb begin
        stg_idx    = op_q[3:2];
        stg_sub    = op_q[1:0];
        stg_ok     = is_stage_op(op_q) && ({1'b0, stg_idx} < NS_L) && (stg_sub != 2'd3);
        stg_onehot = 4'b0001 << stg_idx;
        stg_sel    = stg_onehot[NUM_STAGES-1:0];
    end

    // Next-state, argument assembly and pulse generation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        cmd_d       = cmd_q;
        set_mask_d  = '0;
        set_val_d   = '0;
        set_cfg_d   = '0;
        set_div_d   = 1'b0;
        set_cnt_d   = 1'b0;
        set_flags_d = 1'b0;
        arm_d       = 1'b0;
        soft_rst_d  = 1'b0;
        id_d        = 1'b0;
        meta_d      = 1'b0;
        xon_d       = 1'b0;
        xoff_d      = 1'b0;
`ifdef LOGIP_CMD_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef LOGIP_CMD_TIMEOUT_EN
                tmo_d = '0;
`endif
                if (rx_stb_i) begin
                    if (rx_data_i[7]) begin
                        op_d    = rx_data_i;
                        cnt_d   = 2'd0;
                        state_d = ARG;
`ifdef LOGIP_CMD_TIMEOUT_EN
                        tmo_d   = TW'(TIMEOUT_CYC);
`endif
                    end else begin
                        case (rx_data_i)
                            OP_RESET: soft_rst_d = 1'b1;
                            OP_ARM:   arm_d      = 1'b1;
                            OP_ID:    id_d       = 1'b1;
                            OP_META:  meta_d     = 1'b1;
                            OP_XON:   xon_d      = 1'b1;
                            OP_XOFF:  xoff_d     = 1'b1;
                            default:  ;
                        endcase
                    end
                end
            end

            ARG: begin
                if (rx_stb_i) begin
                    shadow_d = {rx_data_i, shadow_q[23:8]};
                    cnt_d    = cnt_q + 2'd1;
`ifdef LOGIP_CMD_TIMEOUT_EN
                    tmo_d    = TW'(TIMEOUT_CYC);
`endif
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
`ifdef LOGIP_CMD_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                        if (stg_ok) begin
                            cmd_d = {rx_data_i, shadow_q};
                            case (stg_sub)
                                STG_MASK: set_mask_d = stg_sel;
                                STG_VAL:  set_val_d  = stg_sel;
                                STG_CFG:  set_cfg_d  = stg_sel;
                                default:  ;
                            endcase
                        end else if (op_q == OP_DIV) begin
                            cmd_d     = {rx_data_i, shadow_q};
                            set_div_d = 1'b1;
                        end else if (op_q == OP_CNT) begin
                            cmd_d     = {rx_data_i, shadow_q};
                            set_cnt_d = 1'b1;
                        end else if (op_q == OP_FLAGS) begin
                            cmd_d       = {rx_data_i, shadow_q};
                            set_flags_d = 1'b1;
                        end
                    end
                end
`ifdef LOGIP_CMD_TIMEOUT_EN
                else if (tmo_q <= TW'(1)) begin
                    // Host went quiet mid-argument: drop the partial command
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    // State, argument and pulse registers
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            cmd_q       <= '0;
            set_mask_q  <= '0;
            set_val_q   <= '0;
            set_cfg_q   <= '0;
            set_div_q   <= 1'b0;
            set_cnt_q   <= 1'b0;
            set_flags_q <= 1'b0;
            arm_q       <= 1'b0;
            soft_rst_q  <= 1'b0;
            id_q        <= 1'b0;
            meta_q      <= 1'b0;
            xon_q       <= 1'b0;
            xoff_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            cmd_q       <= cmd_d;
            set_mask_q  <= set_mask_d;
            set_val_q   <= set_val_d;
            set_cfg_q   <= set_cfg_d;
            set_div_q   <= set_div_d;
            set_cnt_q   <= set_cnt_d;
            set_flags_q <= set_flags_d;
            arm_q       <= arm_d;
            soft_rst_q  <= soft_rst_d;
            id_q        <= id_d;
            meta_q      <= meta_d;
            xon_q       <= xon_d;
            xoff_q      <= xoff_d;
        end
    end

`ifdef LOGIP_CMD_TIMEOUT_EN
    // Inter-byte timeout down-counter
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign cmd_o       = cmd_q;
    assign set_mask_o  = set_mask_q;
    assign set_val_o   = set_val_q;
    assign set_cfg_o   = set_cfg_q;
    assign set_div_o   = set_div_q;
    assign set_cnt_o   = set_cnt_q;
    assign set_flags_o = set_flags_q;
    assign arm_o       = arm_q;
    assign soft_rst_o  = soft_rst_q;
    assign id_o        = id_q;
    assign meta_o      = meta_q;
    assign xon_o       = xon_q;
    assign xoff_o      = xoff_q;
    assign busy_o      = (state_q == ARG);

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Self-checking bench for sump_cmd_decoder (three trigger stages).
// Every driven cycle the reference model predicts the outputs for the
// following cycle and queues them; a monitor compares on the falling edge.
module tb_sump_cmd_decoder;

    localparam int NS = 3;
`ifdef LOGIP_CMD_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1000;
`endif
    localparam int PW = 3 * NS + 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_stb = 1'b0;
    logic [31:0]   cmd;
    logic [NS-1:0] set_mask, set_val, set_cfg;
    logic          set_div, set_cnt, set_flags, arm, soft_rst, id, meta, xon, xoff, busy;

    sump_cmd_decoder #(.NUM_STAGES(NS), .TIMEOUT_CYC(TMO)) dut (
        .clk_i      (clk),
        .rst_in     (rst_n),
        .rx_data_i  (rx_data),
        .rx_stb_i   (rx_stb),
        .cmd_o      (cmd),
        .set_mask_o (set_mask),
        .set_val_o  (set_val),
        .set_cfg_o  (set_cfg),
        .set_div_o  (set_div),
        .set_cnt_o  (set_cnt),
        .set_flags_o(set_flags),
        .arm_o      (arm),
        .soft_rst_o (soft_rst),
        .id_o       (id),
        .meta_o     (meta),
        .xon_o      (xon),
        .xoff_o     (xoff),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [PW-1:0] pulses;
        logic [31:0]   cmd;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: command-level view of the byte stream
    bit   m_busy = 1'b0;
    int   m_op = 0;
    int   m_args[$];
    logic [31:0] m_cmd = 32'h0;
    int   m_silent = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] dut_pulses();
        return {set_mask, set_val, set_cfg, set_div, set_cnt, set_flags,
                arm, soft_rst, id, meta, xon, xoff};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Predict the outputs one cycle after this input cycle and queue them
    task automatic model_step(input bit stb, input logic [7:0] d);
        logic [NS-1:0] e_mask, e_val, e_cfg;
        logic [8:0]    e_misc;  // div cnt flags arm soft id meta xon xoff
        exp_t          e;
        int            v;
        e_mask = '0; e_val = '0; e_cfg = '0; e_misc = '0;
        if (!m_busy) begin
            if (stb) begin
                v = int'(d);
                if (v < 128) begin
                    case (v)
                        8'h00: e_misc[4] = 1'b1;
                        8'h01: e_misc[5] = 1'b1;
                        8'h02: e_misc[3] = 1'b1;
                        8'h04: e_misc[2] = 1'b1;
                        8'h11: e_misc[1] = 1'b1;
                        8'h13: e_misc[0] = 1'b1;
                        default: ;
                    endcase
                end else begin
                    m_busy = 1'b1;
                    m_op = v;
                    m_args.delete();
                    m_silent = 0;
                end
            end
        end else if (stb) begin
            m_args.push_back(int'(d));
            m_silent = 0;
            if (m_args.size() == 4) begin
                logic [31:0] val;
                val = 32'(m_args[0] + m_args[1] * 256 + m_args[2] * 65536) +
                      (32'(m_args[3]) << 24);
                m_busy = 1'b0;
                if (m_op >= 'hC0 && m_op <= 'hCF) begin
                    int n, k;
                    n = (m_op - 'hC0) / 4;
                    k = (m_op - 'hC0) % 4;
                    if (n < NS && k < 3) begin
                        m_cmd = val;
                        if (k == 0) e_mask[n] = 1'b1;
                        else if (k == 1) e_val[n] = 1'b1;
                        else e_cfg[n] = 1'b1;
                    end
                end else if (m_op == 'h80) begin
                    m_cmd = val; e_misc[8] = 1'b1;
                end else if (m_op == 'h81) begin
                    m_cmd = val; e_misc[7] = 1'b1;
                end else if (m_op == 'h82) begin
                    m_cmd = val; e_misc[6] = 1'b1;
                end
            end
        end else begin
`ifdef LOGIP_CMD_TIMEOUT_EN
            m_silent++;
            if (m_silent == TMO) begin
                m_busy = 1'b0;
                m_args.delete();
            end
`endif
        end
        e.cyc    = cyc + 1;
        e.pulses = {e_mask, e_val, e_cfg, e_misc};
        e.cmd    = m_cmd;
        e.busy   = m_busy;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit stb, input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_stb  = stb;
        rx_data = d;
        model_step(stb, d);
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        drive(1'b1, d);
        repeat (gap) drive(1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    // Wait (bounded) for the scoreboard to drain
    task automatic drain(input string name);
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        idle(1);
        drain("pre-reset drain");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #3;
        check("reset pulses", 64'(dut_pulses()), 64'd0);
        check("reset cmd", 64'(cmd), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        m_busy = 1'b0; m_cmd = 32'h0; m_args.delete(); m_silent = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Scoreboard monitor: compare the queued prediction for this cycle
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                check("missed slot", 64'(exp_q[0].cyc), 64'(cyc));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulses", 64'(dut_pulses()), 64'(e.pulses));
                check("cmd", 64'(cmd), 64'(e.cmd));
                check("busy", 64'(busy), 64'(e.busy));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] shorts[6] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h11, 8'h13};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset pulses", 64'(dut_pulses()), 64'd0);
        check("reset cmd", 64'(cmd), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Short commands, back to back
        send(8'h01, 0); send(8'h02, 0); idle(3);
        send(8'h04, 1); send(8'h11, 1); send(8'h13, 1); send(8'h7F, 1); idle(2);

        // Stage 1 mask, back to back
        send(8'hC4, 0); send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0); idle(3);

        // Stage 2 config with 7-cycle gaps
        send(8'hCA, 7); send(8'h00, 7); send(8'h00, 7); send(8'h00, 7); send(8'h80, 7);

        // Dropped: sub-op 3, then stage 3 (out of range), then divider
        send(8'hC3, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'hCC, 0); send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
        send(8'h80, 0); send(8'h10, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        // Short opcode bytes inside ARG are arguments; new opcode during strobe
        send(8'h81, 0); send(8'h01, 0); send(8'h00, 0); send(8'h02, 0); send(8'h00, 0);
        send(8'h82, 0); send(8'hFF, 0); send(8'hEE, 0); send(8'hDD, 0); send(8'hCC, 0);
        send(8'h01, 0); idle(3);

        // Reset mid-argument, then SUMP 5x 0x00 resync
        send(8'hC1, 0); send(8'hAA, 0); send(8'hBB, 0);
        pulse_reset();
        repeat (5) send(8'h00, 0);
        idle(3);

`ifdef LOGIP_CMD_TIMEOUT_EN
        send(8'hC1, 0); send(8'hAA, 0); idle(20);
        send(8'h01, 0); idle(3);
`endif

        // Randomized stream
        for (int i = 0; i < 500; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 30) b = shorts[$urandom_range(0, 5)];
            else if (r < 50) b = 8'(8'hC0 + $urandom_range(0, 15));
            else if (r < 60) b = 8'(8'h80 + $urandom_range(0, 3));
            else b = 8'($urandom_range(0, 255));
            send(b, ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3));
        end
        idle(6);
        drain("final drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
